fifo_reader: RTL



---
 rtl/fifo_reader.sv | 106 ++++++++++
 1 files changed

// File: rtl/fifo_reader.sv
// Read-side controller for a small byte FIFO: mirrors occupancy from the writer's
// enable, issues single-cycle pops, and hands each popped word downstream on valid/ready.
module fifo_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WEN_MON,
    output logic                  REN,
    input  logic [DATA_WIDTH-1:0] ReadData,
    output logic [DATA_WIDTH-1:0] OutData,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [CW-1:0]         Count,
    output logic                  Empty,
    output logic                  Full,
    output logic                  Overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CAPTURE = 2'd2,
        PRESENT = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            vld_nxt;
    logic            capture;
    logic            push;
    logic            pop;
    logic [CW-1:0]   count_nxt;

    // Occupancy step; a simultaneous push and pop cancel out.
    function automatic logic [CW-1:0] count_step(input logic [CW-1:0] cur,
                                                 input logic          inc,
                                                 input logic          dec);
        logic [CW-1:0] res;
        res = cur;
        if (inc && !dec)
            res = cur + CW'(1);
        else if (dec && !inc)
            res = cur - CW'(1);
        return res;
    endfunction

    assign Empty     = (Count == '0);
    assign Full      = (Count == CW'(DEPTH));
    assign push      = WEN_MON && !Full;
    assign pop       = REN;
    assign count_nxt = count_step(Count, push, pop);

    always_comb begin
        state_nxt = state;
        vld_nxt   = OutValid;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (Count != '0)
                    state_nxt = FETCH;
            end
            FETCH: begin
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                capture   = 1'b1;
                vld_nxt   = 1'b1;
                state_nxt = PRESENT;
            end
            PRESENT: begin
                if (OutReady) begin
                    vld_nxt   = 1'b0;
                    state_nxt = (Count != '0) ? FETCH : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // REN is registered from the next state so it is high exactly while in FETCH.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            REN      <= 1'b0;
            OutValid <= 1'b0;
            OutData  <= '0;
            Count    <= '0;
            Overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            REN      <= (state_nxt == FETCH);
            OutValid <= vld_nxt;
            Count    <= count_nxt;
            if (capture)
                OutData <= ReadData;
            if (WEN_MON && Full)
                Overflow <= 1'b1;
        end
    end

endmodule
